// File: rtl/cr_prefix_ctr_sched.sv
// Drains loaded counter banks in strict block order to a valid/ready stream; ctr_wr->bank_rd 2 cycles, bank_rd->out_valid RD_LAT+1.
// Reads are credit-gated against a RD_LAT+2 deep output FIFO so backpressure never drops a word; CR_PREFIX_SCHED_PERF_EN adds perf counters.

module cr_prefix_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push_vld,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop_rdy,
  output logic                         head_vld,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_vld && (cnt_q != CW'(DEPTH));
    do_pop   = pop_rdy && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_vld = (cnt_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;
endmodule

module cr_prefix_ctr_sched #(
  parameter int NUM_BANKS = 4,
  parameter int N_WORDS   = 64,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS-1:0]           ctr_wr,
  input  logic                           sched_flush,
  output logic [NUM_BANKS-1:0]           bank_rd,
  output logic [$clog2(N_WORDS)-1:0]     bank_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]    bank_rdata,
  output logic [NUM_BANKS-1:0]           bank_clr,
  output logic [NUM_BANKS-1:0]           bank_full,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(NUM_BANKS)-1:0]   out_bank,
  output logic                           out_last,
`ifdef CR_PREFIX_SCHED_PERF_EN
  output logic [15:0]                    perf_bp_cnt,
  output logic [15:0]                    perf_full_cnt,
`endif
  output logic                           sched_ovfl
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AW    = $clog2(N_WORDS);
  localparam int BW    = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_CLEAR} state_t;

  typedef struct packed {
    logic [BW-1:0]     bank;
    logic              last;
    logic [DATA_W-1:0] dat;
  } word_t;

  typedef struct packed {
    logic          vld;
    logic [BW-1:0] bank;
    logic          last;
  } tag_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          cur_q, cur_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [NUM_BANKS-1:0]   pend_q, pend_d;
  logic                   ovfl_q, ovfl_d;
  tag_t                   tag_q [RD_LAT];
  tag_t                   tag_d [RD_LAT];

  logic [NUM_BANKS-1:0]   cur_oh;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_cnt;
  logic [CW:0]            occ;
  logic                   has_credit;
  logic                   rd_go;
  logic                   fifo_vld;
  word_t                  push_w, head_w;

  assign cur_oh    = NUM_BANKS'(1) << cur_q;
  assign bank_full = pend_q | ((state_q != ST_IDLE) ? cur_oh : '0);

  // Anything already issued but not yet accepted downstream holds a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag_q[i].vld);
    occ        = {1'b0, fifo_cnt} + {1'b0, inflight};
    has_credit = (occ < (CW+1)'(DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    addr_d   = addr_q;
    pend_d   = pend_q | ctr_wr;
    ovfl_d   = ovfl_q | (|(ctr_wr & pend_q));
    bank_rd  = '0;
    bank_clr = '0;
    rd_go    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q[cur_q]) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        if (has_credit) begin
          rd_go   = 1'b1;
          bank_rd = cur_oh;
          addr_d  = addr_q + 1'b1;
          if (addr_q == AW'(N_WORDS-1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        bank_clr = cur_oh;
        pend_d   = (pend_q & ~cur_oh) | ctr_wr;
        cur_d    = cur_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins: release every held bank, keep only loads arriving now.
    if (sched_flush) begin
      state_d  = ST_IDLE;
      cur_d    = '0;
      addr_d   = '0;
      pend_d   = ctr_wr;
      bank_rd  = '0;
      rd_go    = 1'b0;
      bank_clr = bank_full;
    end
  end

  always_comb begin
    tag_d[0].vld  = rd_go;
    tag_d[0].bank = cur_q;
    tag_d[0].last = (addr_q == AW'(N_WORDS-1));
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    if (sched_flush) begin
      for (int i = 0; i < RD_LAT; i++) tag_d[i].vld = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      addr_q  <= '0;
      pend_q  <= '0;
      ovfl_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      ovfl_q  <= ovfl_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  always_comb begin
    push_w.bank = tag_q[RD_LAT-1].bank;
    push_w.last = tag_q[RD_LAT-1].last;
    push_w.dat  = bank_rdata[tag_q[RD_LAT-1].bank*DATA_W +: DATA_W];
  end

  cr_prefix_sched_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (sched_flush),
    .push_vld (tag_q[RD_LAT-1].vld && !sched_flush),
    .push_dat (push_w),
    .pop_rdy  (out_ready),
    .head_vld (fifo_vld),
    .head_dat (head_w),
    .cnt      (fifo_cnt)
  );

  assign out_valid  = fifo_vld;
  assign out_data   = fifo_vld ? head_w.dat  : '0;
  assign out_bank   = fifo_vld ? head_w.bank : '0;
  assign out_last   = fifo_vld ? head_w.last : 1'b0;
  assign bank_addr  = addr_q;
  assign sched_ovfl = ovfl_q;

`ifdef CR_PREFIX_SCHED_PERF_EN
  logic [15:0] bp_cnt_q, bp_cnt_d, full_cnt_q, full_cnt_d;

  always_comb begin
    bp_cnt_d   = bp_cnt_q;
    full_cnt_d = full_cnt_q;
    if (out_valid && !out_ready && bp_cnt_q != 16'hFFFF) bp_cnt_d = bp_cnt_q + 16'd1;
    if ((|bank_full) && full_cnt_q != 16'hFFFF) full_cnt_d = full_cnt_q + 16'd1;
    if (sched_flush) begin
      bp_cnt_d   = '0;
      full_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_cnt_q   <= '0;
      full_cnt_q <= '0;
    end else begin
      bp_cnt_q   <= bp_cnt_d;
      full_cnt_q <= full_cnt_d;
    end
  end

  assign perf_bp_cnt   = bp_cnt_q;
  assign perf_full_cnt = full_cnt_q;
`endif
endmodule

// File: tb/tb_cr_prefix_ctr_sched.sv
// Directed bench for cr_prefix_ctr_sched: cycle-exact single-bank drain, ordering, backpressure, flush, overflow, reset.
module tb_cr_prefix_ctr_sched;
  localparam int NB = 4;
  localparam int NW = 64;
  localparam int DW = 32;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NB-1:0]     ctr_wr = '0;
  logic              sched_flush = 1'b0;
  logic [NB-1:0]     bank_rd;
  logic [5:0]        bank_addr;
  logic [NB*DW-1:0]  bank_rdata;
  logic [NB-1:0]     bank_clr;
  logic [NB-1:0]     bank_full;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_bank;
  logic              out_last;
  logic              sched_ovfl;
`ifdef CR_PREFIX_SCHED_PERF_EN
  logic [15:0]       perf_bp_cnt;
  logic [15:0]       perf_full_cnt;
`endif

  cr_prefix_ctr_sched #(
    .NUM_BANKS (NB),
    .N_WORDS   (NW),
    .DATA_W    (DW),
    .RD_LAT    (RL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ctr_wr      (ctr_wr),
    .sched_flush (sched_flush),
    .bank_rd     (bank_rd),
    .bank_addr   (bank_addr),
    .bank_rdata  (bank_rdata),
    .bank_clr    (bank_clr),
    .bank_full   (bank_full),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_bank    (out_bank),
    .out_last    (out_last),
`ifdef CR_PREFIX_SCHED_PERF_EN
    .perf_bp_cnt   (perf_bp_cnt),
    .perf_full_cnt (perf_full_cnt),
`endif
    .sched_ovfl  (sched_ovfl)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fdat(input int b, input int a);
    return {8'(8'h11 * (b + 1)), 8'h5A, 8'(a), 8'(a ^ 8'h3C)};
  endfunction

  // Bank memory model: data reflects the address strobed RD_LAT cycles earlier.
  logic [5:0] addr_d1, addr_d2;
  always @(posedge clk) begin
    addr_d1 <= bank_addr;
    addr_d2 <= addr_d1;
  end
  always_comb begin
    bank_rdata = '0;
    for (int i = 0; i < NB; i++) bank_rdata[i*DW +: DW] = fdat(i, int'(addr_d2));
  end

  logic [34:0] exp_q[$];
  task automatic push_bank(input int b);
    for (int a = 0; a < NW; a++) exp_q.push_back({2'(b), (a == NW - 1), fdat(b, a)});
  endtask

  int          rd_seen = 0;
  int          rd_since = 0;
  int          acc_since = 0;
  logic        stall_q = 1'b0;
  logic [34:0] stall_w;
  logic [34:0] mon_w;

  always @(negedge clk) begin
    mon_w = {out_bank, out_last, out_data};
    if (rst) begin
      stall_q   = 1'b0;
      rd_since  = 0;
      acc_since = 0;
    end else begin
      if (stall_q) chk("stall_hold", {out_valid, mon_w}, {1'b1, stall_w});
      if (bank_rd != '0) begin
        rd_seen++;
        rd_since++;
      end
      if (out_valid && out_ready) begin
        acc_since++;
        if (exp_q.size() == 0) chk("unexpected_word", out_valid, 0);
        else chk("word", mon_w, exp_q.pop_front());
      end
      if (bank_rd != '0) chk("credit_bound", (rd_since - acc_since) <= RL + 2, 1);
      stall_q = out_valid && !out_ready && !sched_flush;
      stall_w = mon_w;
      if (sched_flush) begin
        rd_since  = 0;
        acc_since = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bp_pat = 4'b1001;

  task automatic wait_done(input string tag, input bit bp);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && bank_full == '0) && n < 2000) begin
      tick();
      if (bp) out_ready = bp_pat[n % 4];
      n++;
      @(negedge clk);
    end
    chk(tag, {exp_q.size(), bank_full}, 0);
    tick();
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] e_rd, e_clr, e_full;
    logic [5:0] e_addr;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {bank_rd, bank_clr, bank_full, out_valid, out_last, sched_ovfl, bank_addr, out_bank}, 0);
    chk("rst_data", out_data, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("idle_after_rst", {bank_rd, bank_full, out_valid}, 0);
    tick();

    // Single bank, cycle exact relative to the ctr_wr cycle (k=0).
    push_bank(0);
    ctr_wr = 4'b0001;
    for (int k = 0; k < 76; k++) begin
      @(negedge clk);
      e_rd   = (k >= 2 && k <= 65) ? 4'b0001 : 4'b0000;
      e_addr = (k >= 2 && k <= 65) ? 6'(k - 2) : 6'd0;
      e_clr  = (k == 70) ? 4'b0001 : 4'b0000;
      e_full = (k >= 1 && k <= 70) ? 4'b0001 : 4'b0000;
      chk($sformatf("t1_cyc%0d", k), {bank_rd, bank_addr, out_valid, out_last, bank_clr, bank_full},
          {e_rd, e_addr, (k >= 5 && k <= 68), (k == 68), e_clr, e_full});
      tick();
      ctr_wr = '0;
    end
    chk("t1_all_words", exp_q.size(), 0);

    // Banks 1,2,3 loaded together with cur=1.
    push_bank(1); push_bank(2); push_bank(3);
    ctr_wr = 4'b1110;
    tick();
    ctr_wr = '0;
    wait_done("t2_done", 1'b0);

    // Bank 2 loaded out of order waits for bank 0.
    n = rd_seen;
    ctr_wr = 4'b0100;
    tick();
    ctr_wr = '0;
    repeat (20) tick();
    @(negedge clk);
    chk("t4_no_rd", rd_seen - n, 0);
    chk("t4_full", {out_valid, bank_full}, {1'b0, 4'b0100});
    tick();
    push_bank(0); push_bank(1); push_bank(2);
    ctr_wr = 4'b0011;
    tick();
    ctr_wr = '0;
    wait_done("t4_done", 1'b0);

    // Bank 3 under 1,0,0,1 backpressure.
    push_bank(3);
    ctr_wr = 4'b1000;
    tick();
    ctr_wr = '0;
    wait_done("t3_bp_done", 1'b1);

    // Flush at addr 20 of bank 1 with a bank 0 load in the same cycle.
    push_bank(0); push_bank(1);
    ctr_wr = 4'b0011;
    tick();
    ctr_wr = '0;
    n = 0;
    while (!(bank_rd[1] && bank_addr == 6'd20) && n < 500) begin
      tick();
      n++;
    end
    chk("t5_reach_addr20", {bank_rd, bank_addr}, {4'b0010, 6'd20});
    sched_flush = 1'b1;
    ctr_wr = 4'b0001;
    #1;
    chk("t5_flush_clr", bank_clr, 4'b0010);
    tick();
    sched_flush = 1'b0;
    ctr_wr = '0;
    exp_q.delete();
    push_bank(0);
    @(negedge clk);
    chk("t5_after_flush", {out_valid, bank_rd, bank_full, bank_clr}, {1'b0, 4'b0000, 4'b0001, 4'b0000});
    tick();
    @(negedge clk);
    chk("t5_restart", {bank_rd, bank_addr}, {4'b0001, 6'd0});
    tick();
    wait_done("t5_done", 1'b0);

    // Double load of bank 3 while it waits behind cur=1.
    ctr_wr = 4'b1000;
    tick();
    ctr_wr = '0;
    @(negedge clk);
    chk("t6_first", {sched_ovfl, bank_full, bank_rd}, {1'b0, 4'b1000, 4'b0000});
    tick();
    ctr_wr = 4'b1000;
    tick();
    ctr_wr = '0;
    @(negedge clk);
    chk("t6_ovfl_set", sched_ovfl, 1);
    tick();
    push_bank(1); push_bank(2); push_bank(3);
    ctr_wr = 4'b0110;
    tick();
    ctr_wr = '0;
    wait_done("t6_done", 1'b0);
    @(negedge clk);
    chk("t6_ovfl_sticky", sched_ovfl, 1);
    tick();

    // Asynchronous reset in the middle of a drain.
    push_bank(0);
    ctr_wr = 4'b0001;
    tick();
    ctr_wr = '0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid", {bank_rd, bank_clr, bank_full, out_valid, sched_ovfl}, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_idle", {bank_full, bank_rd, bank_clr, out_valid, sched_ovfl}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cr_prefix_ctr_sched.md
Name: cr_prefix_ctr_sched

Overview:
Scheduler that drains the prefix feature-extraction counter banks after the inbound controller finishes loading them. It tracks which banks are loaded, reads each bank in strict block order (bank 0..NUM_BANKS-1, wrapping), and streams the words through a valid/ready interface to the prefix-table builder. When a bank is fully delivered, it clears the bank and releases it back to the loader. Its per-bank full outputs drive the loader's counter-full inputs.

Parameters:
NUM_BANKS, 4, number of counter banks; power of 2.
N_WORDS, 64, words read per bank; power of 2, ≥2.
DATA_W, 32, counter word width.
RD_LAT, 2, bank read latency in cycles, ≥1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ctr_wr  in  NUM_BANKS  load-complete pulse per bank; several bits may be set together
sched_flush  in  1  synchronous abort of all pending/active work
bank_rd  out  NUM_BANKS  one-hot read strobe
bank_addr  out  log2(N_WORDS)  read address
bank_rdata  in  NUM_BANKS*DATA_W  read data, bank i at [i*DATA_W +: DATA_W], valid RD_LAT cycles after the strobe
bank_clr  out  NUM_BANKS  one-cycle clear pulse
bank_full  out  NUM_BANKS  bank i is pending or being drained
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_W  counter word
out_bank  out  log2(NUM_BANKS)  source bank
out_last  out  1  final word of the bank
sched_ovfl  out  1  sticky error: ctr_wr hit a bank whose pend bit was already set

Behaviour:
- Reset: all outputs 0; pend=0; cur=0; FSM in IDLE; output FIFO empty; read tag pipe empty.
- pend[i] is set the cycle after ctr_wr[i]. It is cleared in CLEAR for bank cur, or by flush.
- If ctr_wr[i] arrives while pend[i]=1, set sched_ovfl; pend[i] stays 1. sched_ovfl clears only on rst.
- bank_full[i] = pend[i] | (state≠IDLE & cur==i). This is combinational from registers.
- FSM:
  - IDLE: if pend[cur], go to READ with addr=0.
  - READ: issue bank_rd[cur] at addr when credit>0, then addr+1. After the strobe at addr=N_WORDS-1, go to DRAIN.
  - DRAIN: when inflight==0, FIFO empty, and the last word has been accepted, go to CLEAR.
  - CLEAR: pulse bank_clr[cur] for one cycle; clear pend[cur]; cur=cur+1 mod NUM_BANKS; go to IDLE.
- Latency:
  - ctr_wr at cycle N gives the first bank_rd at N+2.
  - bank_rd at cycle M puts the word in the FIFO at M+RD_LAT. out_valid follows at M+RD_LAT+1 (registered FIFO output).
- Credit and FIFO:
  - Output FIFO depth = RD_LAT+2. credit = depth − fifo_count − inflight.
  - No read is issued without credit, so no returned word is ever dropped under backpressure.
- Back-to-back throughput: with out_ready held at 1, one word per cycle.
- Handshake:
  - out_data, out_bank and out_last hold stable while out_valid & ~out_ready.
  - out_last=1 only on the word read from addr N_WORDS-1.
- Order:
  - Banks are drained only in cur order.
  - A pending bank ≠ cur waits, even if cur is not pending. This matches the loader's sequential block fill.
- Flush (priority over everything):
  - Next cycle: state=IDLE, cur=0, FIFO emptied, read tags invalidated (in-flight returns discarded).
  - bank_clr pulses for every bank with pend or active.
  - out_valid=0.
  - ctr_wr bits asserted in the same cycle as flush are recorded after the flush (pend=ctr_wr).
- Reset mid-operation: async return to reset values; no clr pulse.

Optional Feature:
CR_PREFIX_SCHED_PERF_EN:
- Defined: adds outputs perf_bp_cnt[15:0] and perf_full_cnt[15:0], both saturating.
  - perf_bp_cnt counts cycles with out_valid & ~out_ready.
  - perf_full_cnt counts cycles with |bank_full.
  - Both clear on rst or sched_flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Single bank, N_WORDS=64, RD_LAT=2, out_ready=1: ctr_wr=0001 at cycle 10 -> bank_rd[0] cycles 12..75, addr 0..63; out_valid cycles 15..78; out_last at 78; bank_clr[0] pulse; bank_full[0] low afterwards; cur=1.
2. Multi-bank eot case: ctr_wr=1110 with cur=1 -> banks 1,2,3 drained in order; out_bank sequence 1,2,3; each bank gives 64 words and one out_last.
3. Backpressure: out_ready toggled 1,0,0,1 repeatedly during a bank -> no word lost or duplicated; out_data stable while stalled; FIFO never exceeds 4 entries; reads pause when credit=0.
4. Order stall: cur=0, ctr_wr=0100 -> no bank_rd issued and bank_full[2]=1. Later ctr_wr=0011 -> banks 0,1,2 drained in order.
5. Flush mid-read at addr 20 of bank 1, ctr_wr=0001 in the same cycle -> bank_clr=0010; no further out_valid from bank 1; cur=0; pend=0001; bank 0 drain starts 2 cycles later.
6. Overflow: ctr_wr[3] twice while bank 3 is pending -> sched_ovfl=1 and stays 1 until rst; bank 3 is drained once.
